// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl
//   Collects FRAME_LEN nibbles of a frame and produces the frame's even-parity
//   bit, which is the XOR of every accepted data bit. The result is held until
//   the consumer acknowledges it.
//
//   Handshakes:
//     nib_valid/nib_ready : a nibble is transferred on a rising edge where both
//                           are 1. nib_ready depends only on state, never on
//                           nib_valid. The source may hold nib_valid low for
//                           any number of cycles; there is no timeout.
//     par_valid/par_ack   : the result is transferred on a rising edge where
//                           both are 1. par_valid and par_out stay stable until
//                           that edge.
//
//   Ports:
//     clk        single clock; all state changes on the rising edge
//     rst_n      asynchronous, active-low reset
//     start      opens a new frame; sampled only in IDLE
//     abort      cancels the frame or the pending result; no result is made
//     nib_valid  nib_data is valid
//     nib_data   data nibble
//     nib_ready  block accepts a nibble this cycle (ACCUM only)
//     par_valid  frame parity result is available
//     par_out    even-parity bit of the frame
//     par_ack    consumer takes the result
//     busy       high in ACCUM or DONE
//
//   Optional feature, macro PARITY_CHECK_EN:
//     exp_par    expected frame parity, sampled with the last nibble
//     par_err    final parity differs from exp_par; held through DONE
//
//   The FSM state is kept in the signal 'state' for observation.
module parity_frame_ctrl #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       nib_valid,
  input  logic [3:0] nib_data,
  output logic       nib_ready,
  output logic       par_valid,
  output logic       par_out,
  input  logic       par_ack,
  output logic       busy
`ifdef PARITY_CHECK_EN
  ,
  input  logic       exp_par,
  output logic       par_err
`endif
);

  // Wide enough to hold FRAME_LEN itself, so the counter never wraps.
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic          acc;
  logic [CW-1:0] cnt;

  logic nib_par;
  logic accept;
  logic last_nib;
  logic final_par;

  assign nib_ready = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign nib_par   = ^nib_data;
  assign accept    = nib_valid && nib_ready;
  assign last_nib  = (cnt == LAST_IDX);
  // Parity including the nibble being accepted this cycle.
  assign final_par = acc ^ nib_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 1'b0;
      cnt       <= '0;
      par_out   <= 1'b0;
      par_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort wins over start.
          if (start && !abort) begin
            acc   <= 1'b0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (abort) begin
            // A nibble handshaked in the same cycle is dropped with the frame.
            acc   <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (accept) begin
            acc <= final_par;
            cnt <= cnt + 1'b1;
            if (last_nib) begin
              par_out   <= final_par;
              par_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // abort leaves DONE exactly like an acknowledge.
          if (par_ack || abort) begin
            par_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          par_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  // Registered on the same edge as par_out; cleared on every exit from DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (abort) begin
            par_err <= 1'b0;
          end else if (accept && last_nib) begin
            par_err <= (final_par != exp_par);
          end
        end
        DONE: begin
          if (par_ack || abort) begin
            par_err <= 1'b0;
          end
        end
        default: par_err <= 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 Parameter: FRAME_LEN, 8, number of nibbles per frame; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to open a new frame; sampled only in IDLE.
REQ-005 Port: abort  input  1  cancel the frame in progress; no result is produced.
REQ-006 Port: nib_valid  input  1  nib_data is valid.
REQ-007 Port: nib_data  input  4  data nibble.
REQ-008 Port: nib_ready  output  1  block accepts a nibble this cycle.
REQ-009 Port: par_valid  output  1  frame parity result is available.
REQ-010 Port: par_out  output  1  even-parity bit of the frame (XOR of all accepted bits).
REQ-011 Port: par_ack  input  1  consumer takes the result.
REQ-012 Port: busy  output  1  high in ACCUM or DONE.

Function
REQ-013 The FSM SHALL have three states, encoded in 2 bits: IDLE, ACCUM and DONE.
REQ-014 In IDLE, start=1 with abort=0 SHALL clear the accumulator and the nibble counter, then enter ACCUM on the next edge.
REQ-015 In IDLE, start=1 with abort=1 SHALL keep the block in IDLE, because abort has priority.
REQ-016 nib_ready SHALL be 1 only in ACCUM and SHALL be driven combinationally from state.
REQ-017 A nibble is accepted when nib_valid and nib_ready are both 1.
REQ-018 On acceptance: acc <= acc ^ nib_data[3] ^ nib_data[2] ^ nib_data[1] ^ nib_data[0], and counter <= counter + 1.
REQ-019 nib_valid=0 cycles in ACCUM SHALL hold acc and counter unchanged, with no timeout.
REQ-020 Acceptance with counter == FRAME_LEN-1 SHALL load par_out with the final acc and set par_valid, then enter DONE on the next edge.
REQ-021 Result latency SHALL be 1 cycle after the last accepted nibble.
REQ-022 The counter SHALL be $clog2(FRAME_LEN+1) bits wide and SHALL never wrap within a frame.
REQ-023 In DONE, par_valid and par_out SHALL hold stable until par_ack=1.
REQ-024 par_ack=1 in DONE SHALL clear par_valid and return to IDLE on the next edge.
REQ-025 par_ack SHALL be ignored outside DONE.
REQ-026 abort=1 in ACCUM SHALL return to IDLE and discard acc; any nibble handshaked in that same cycle SHALL be dropped.
REQ-027 abort=1 in DONE SHALL clear par_valid and return to IDLE, identical to par_ack.
REQ-028 start=1 in ACCUM or DONE SHALL be ignored.
REQ-029 A new start is accepted no earlier than the first IDLE cycle after DONE exits, so there is 1 IDLE cycle minimum between frames.

Reset
REQ-030 rst_n=0 SHALL force IDLE immediately, regardless of clk.
REQ-031 Reset values: acc=0, counter=0, par_out=0, par_valid=0, nib_ready=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL discard all progress; after deassertion the block waits for a new start.

Configuration
REQ-033 Macro PARITY_CHECK_EN, when defined, SHALL add port exp_par (input, 1, expected frame parity, sampled with the last nibble) and port par_err (output, 1).
REQ-034 With PARITY_CHECK_EN, par_err SHALL be registered together with par_out as (final acc != exp_par), held through DONE, and cleared on exit from DONE, on abort and on reset.
REQ-035 Without PARITY_CHECK_EN, neither port exists and no checker logic is synthesized; all other behaviour is identical.

Verification (FRAME_LEN=4 unless noted)
REQ-036 Back-to-back frame: start, then nibbles 0x1,0x3,0x7,0xF on consecutive cycles -> par_valid 1 cycle after the 4th nibble, par_out=0; par_ack -> IDLE, busy=0.
REQ-037 Gapped frame: nibbles 0x1,0x0,0x0,0x0 with 2 idle nib_valid cycles between each -> par_out=1, counter does not advance during the gaps.
REQ-038 Abort: abort asserted in the same cycle as the 2nd nibble -> IDLE, no par_valid; a new frame 0x8,0x8,0x8,0x8 -> par_out=0.
REQ-039 Async reset: rst_n=0 mid-cycle after the 3rd nibble -> outputs go to reset values without waiting for a clk edge; start ignored while rst_n=0.
REQ-040 Hold and priority: par_ack withheld for 10 cycles -> par_valid and par_out stable; start together with abort in IDLE -> remains IDLE.
REQ-041 With PARITY_CHECK_EN: nibbles 0xF,0xF,0xF,0x1 with exp_par=0 -> par_out=1, par_err=1; the same frame with exp_par=1 -> par_err=0.
